// File: rtl/fetch_unit.sv
// Instruction fetch stage for a non-pipelined core.
// Owns the PC and fetches one instruction at a time over a valid/ready
// request / valid response memory port. It presents the instruction to
// decode, then waits for execute to resolve the next PC before fetching
// again. A misaligned next PC raises a sticky fault and halts fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        upd_valid,
    input  logic [1:0]  pc_select,
    input  logic [31:0] pc_offset,
    input  logic [31:0] jalr_target,
    output logic [31:0] pc_plus4,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_RSP = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] inst_out_r;
    logic [31:0] inst_pc_r;
    logic        req_valid_r;
    logic        inst_valid_r;
    logic        fault_r;
    logic        req_valid_next_s;
    logic        inst_valid_next_s;
    logic [31:0] next_pc_s;
    logic        next_misaligned_s;
    logic        req_fire_s;
    logic        upd_fire_s;

    // The request valid is registered, so it is low for the first cycle
    // after reset even though the state is already FETCH.
    assign req_fire_s        = req_valid_r && imem_req_ready;
    assign upd_fire_s        = (state_r == ST_EXEC) && upd_valid;
    assign next_misaligned_s = (next_pc_s[1:0] != 2'b00);

    // Resolve the next PC from the execute-stage selection (11 behaves as 00).
    always_comb begin
        next_pc_s = inst_pc_r + 32'd4;
        case (pc_select)
            2'b01:   next_pc_s = inst_pc_r + pc_offset;
            2'b10:   next_pc_s = jalr_target & ~32'h0000_0001;
            default: next_pc_s = inst_pc_r + 32'd4;
        endcase
    end

    // State register; reset wins over any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (req_fire_s) begin
                    state_next_s = ST_WAIT_RSP;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_WAIT_RSP;
                end
            end
            ST_ISSUE: begin
                if (inst_ready) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_EXEC: begin
                if (!upd_valid) begin
                    state_next_s = ST_EXEC;
                end else if (next_misaligned_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALT:  state_next_s = ST_HALT;
            default:  state_next_s = ST_HALT;
        endcase
    end

    // Output decode: handshake valids follow the state being entered.
    always_comb begin
        req_valid_next_s  = (state_next_s == ST_FETCH);
        inst_valid_next_s = (state_next_s == ST_ISSUE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            inst_out_r   <= 32'h0000_0000;
            inst_pc_r    <= 32'h0000_0000;
            req_valid_r  <= 1'b0;
            inst_valid_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            req_valid_r  <= req_valid_next_s;
            inst_valid_r <= inst_valid_next_s;
            if ((state_r == ST_WAIT_RSP) && imem_rsp_valid) begin
                inst_out_r <= imem_rsp_data;
                inst_pc_r  <= pc_r;
            end
            if (upd_fire_s && !next_misaligned_s) begin
                pc_r <= next_pc_s;
            end
            if (upd_fire_s && next_misaligned_s) begin
                fault_r <= 1'b1;
            end
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = inst_valid_r;
    assign inst_out       = inst_out_r;
    assign inst_pc        = inst_pc_r;
    assign fault          = fault_r;
    assign pc_plus4       = inst_pc_r + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver plays instruction memory,
// decode and execute, pushing expected request addresses and instructions
// into queues; an independent monitor pops and compares on each handshake.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        upd_valid;
    logic [1:0]  pc_select;
    logic [31:0] pc_offset;
    logic [31:0] jalr_target;
    logic [31:0] pc_plus4;
    logic        fault;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .upd_valid      (upd_valid),
        .pc_select      (pc_select),
        .pc_offset      (pc_offset),
        .jalr_target    (jalr_target),
        .pc_plus4       (pc_plus4),
        .fault          (fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_t;

    logic [31:0] addr_q[$];
    inst_t       inst_q[$];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_pc;
    logic        halted = 1'b0;
    logic        stall_seen = 1'b0;
    logic [31:0] stall_addr = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Monitor: compare every handshake against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            stall_seen <= 1'b0;
        end else begin
            if (stall_seen) begin
                chk("req_addr_hold", imem_req_addr, stall_addr);
                chk1("req_valid_hold", imem_req_valid, 1'b1);
            end
            stall_seen <= imem_req_valid && !imem_req_ready;
            stall_addr <= imem_req_addr;
            if (imem_req_valid && imem_req_ready) begin
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got addr %h expected no request", imem_req_addr);
                end else begin
                    chk("req_addr", imem_req_addr, addr_q[0]);
                    addr_q.delete(0);
                end
            end
            if (inst_valid && inst_ready) begin
                if (inst_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inst: got %h expected no instruction", inst_out);
                end else begin
                    chk("inst_out", inst_out, inst_q[0].inst);
                    chk("inst_pc", inst_pc, inst_q[0].pc);
                    inst_q.delete(0);
                end
            end
            if (halted) begin
                chk1("halt_no_req", imem_req_valid, 1'b0);
                chk1("halt_no_inst", inst_valid, 1'b0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        halted         = 1'b0;
        model_pc       = RST_PC;
        addr_q.delete();
        inst_q.delete();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!imem_req_valid) begin
            tests++;
            fails++;
            $display("FAIL timeout_req: got no imem_req_valid expected one within 50 cycles");
            finish_tb();
        end
    endtask

    task automatic wait_inst();
        int n = 0;
        while (!inst_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!inst_valid) begin
            tests++;
            fails++;
            $display("FAIL timeout_inst: got no inst_valid expected one within 50 cycles");
            finish_tb();
        end
    endtask

    // One full fetch/issue/execute round trip with optional stalls.
    task automatic do_instr(input logic [31:0] data, input int req_stall, input int rsp_delay,
                            input int inst_stall, input logic [1:0] sel,
                            input logic [31:0] off, input logic [31:0] jt);
        logic [31:0] nxt;
        addr_q.push_back(model_pc);
        wait_req();
        repeat (req_stall) begin
            @(posedge clk);
            #1;
        end
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        repeat (rsp_delay) begin
            @(posedge clk);
            #1;
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        inst_q.push_back('{pc: model_pc, inst: data});
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        wait_inst();
        repeat (inst_stall) begin
            upd_valid = 1'($urandom_range(0, 1));
            pc_select = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        upd_valid  = 1'b0;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        // stray response while executing must be ignored
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~data;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        chk1("exec_inst_valid", inst_valid, 1'b0);
        chk1("exec_req_valid", imem_req_valid, 1'b0);
        chk("exec_inst_out", inst_out, data);
        chk("exec_inst_pc", inst_pc, model_pc);
        chk("exec_pc_plus4", pc_plus4, model_pc + 32'd4);
        upd_valid   = 1'b1;
        pc_select   = sel;
        pc_offset   = off;
        jalr_target = jt;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        case (sel)
            2'b01:   nxt = model_pc + off;
            2'b10:   nxt = {jt[31:1], 1'b0};
            default: nxt = model_pc + 32'd4;
        endcase
        if (nxt[1:0] != 2'b00) begin
            halted = 1'b1;
            chk1("fault_set", fault, 1'b1);
            repeat (6) begin
                @(posedge clk);
                #1;
            end
            chk1("fault_sticky", fault, 1'b1);
        end else begin
            model_pc = nxt;
            chk1("fault_clear", fault, 1'b0);
        end
    endtask

    task automatic run_random();
        logic [1:0]  sel;
        logic [31:0] off;
        logic [31:0] jt;
        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(0, 3));
            off = $urandom & 32'hFFFF_FFFC;
            jt  = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 9) == 0) begin
                off[1:0] = 2'($urandom_range(1, 3));
                jt[1]    = 1'b1;
            end
            do_instr($urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 2), sel, off, jt);
            if (halted) begin
                do_reset();
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        upd_valid      = 1'b0;
        pc_select      = 2'b00;
        pc_offset      = 32'h0;
        jalr_target    = 32'h0;
        model_pc       = RST_PC;
        do_reset();

        // basic fetch at reset PC, sequential next
        do_instr(32'h0000_0013, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        // jump to 0x200 via jalr
        do_instr(32'h1111_1111, 0, 1, 0, 2'b10, 32'h0, 32'h0000_0200);
        // taken backward branch: 0x200 - 16 = 0x1F0
        do_instr(32'h2222_2222, 0, 0, 1, 2'b01, 32'hFFFF_FFF0, 32'h0);
        // backpressure on both handshakes; jalr with odd target -> 0x304
        do_instr(32'h3333_3333, 3, 2, 2, 2'b10, 32'h0, 32'h0000_0305);
        // jump to top of address space, then wrap to 0
        do_instr(32'h4444_4444, 0, 0, 0, 2'b10, 32'h0, 32'hFFFF_FFFC);
        do_instr(32'h5555_5555, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        // 11 behaves as pc+4
        do_instr(32'h6666_6666, 0, 0, 0, 2'b11, 32'h8, 32'h40);
        // jump to 0x10, then misaligned branch to 0x12 -> fault and halt
        do_instr(32'h7777_7777, 0, 0, 0, 2'b10, 32'h0, 32'h0000_0010);
        do_instr(32'h8888_8888, 0, 0, 0, 2'b01, 32'h0000_0002, 32'h0);
        do_reset();

        // reset while waiting for a response that arrives in the same cycle
        addr_q.push_back(model_pc);
        wait_req();
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        do_reset();
        do_instr(32'h0000_0093, 0, 0, 0, 2'b00, 32'h0, 32'h0);

        run_random();

        repeat (3) @(posedge clk);
        #1;
        chk("addr_q_drained", 32'(addr_q.size()), 32'h0);
        chk("inst_q_drained", 32'(inst_q.size()), 32'h0);
        finish_tb();
    end

endmodule
